// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: command FIFO plus issue FSM in front of an ALSU that has
// input and output registers (2-cycle latency). Each popped command is driven
// onto registered ALSU operand/control outputs, and its tag and illegal flag
// are delayed to line up with the ALSU result.
// Optional build macro: ALSU_ISSUER_STATS_EN adds saturating issued_cnt and
// illegal_cnt outputs. These counters are cleared by reset only.
module alsu_cmd_issuer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_data,
  input  logic [3:0]               cmd_tag,
  input  logic                     hold,
  input  logic                     flush,
  output logic [2:0]               A,
  output logic [2:0]               B,
  output logic [2:0]               opcode,
  output logic                     Cin,
  output logic                     serial_in,
  output logic                     red_op_A,
  output logic                     red_op_B,
  output logic                     bypass_A,
  output logic                     bypass_B,
  output logic                     direction,
  output logic                     issue_valid,
  output logic                     rsp_valid,
  output logic [3:0]               rsp_tag,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALSU_ISSUER_STATS_EN
  ,
  output logic [15:0]              issued_cnt,
  output logic [15:0]              illegal_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // NOP drive: every field zero except bypass_A.
  localparam logic [15:0] NOP = 16'h2000;

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] data;
  } entry_t;

  state_t               state_q, state_d;
  entry_t [DEPTH-1:0]   mem_q, mem_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [15:0]          drv_q, drv_d;
  logic                 ivld_q, ivld_d;
  logic [3:0]           itag_q, itag_d;
  logic                 iill_q, iill_d;
  logic [1:0]           vld_pipe_q, vld_pipe_d;
  logic [1:0][3:0]      tag_pipe_q, tag_pipe_d;
  logic [1:0]           ill_pipe_q, ill_pipe_d;

  logic   full, pop, push, head_ill;
  entry_t head;

  function automatic logic is_illegal(input logic [15:0] d);
    logic [2:0] op;
    op = d[8:6];
    return (op == 3'b110) || (op == 3'b111) ||
           ((d[11] | d[12]) && (op != 3'b000) && (op != 3'b001));
  endfunction

  // Pop is gated by the live hold, so hold stops issue the next cycle.
  // Flush also blocks pop and push. A full FIFO still takes a push in a pop cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = (state_q == ISSUE) && !hold && !flush;
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready && !flush;
  assign head      = mem_q[rptr_q];
  assign head_ill  = is_illegal(head.data);

  // FIFO storage, pointers and occupancy. Pointers wrap because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = {cmd_tag, cmd_data};
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next state is computed from the occupancy after this cycle's update and from hold.
  always_comb begin
    state_d = ISSUE;
    if (count_d == '0) state_d = IDLE;
    else if (hold)     state_d = STALL;
  end

  // Issue drive register, plus the 2-stage tag/illegal pipe that matches ALSU latency.
  always_comb begin
    drv_d      = NOP;
    ivld_d     = pop;
    itag_d     = '0;
    iill_d     = 1'b0;
    if (pop) begin
      drv_d  = head.data;
      itag_d = head.tag;
      iill_d = head_ill;
    end
    vld_pipe_d = {vld_pipe_q[0], ivld_q};
    tag_pipe_d = {tag_pipe_q[0], itag_q};
    ill_pipe_d = {ill_pipe_q[0], iill_q};
    if (flush) begin
      vld_pipe_d = '0;
      tag_pipe_d = '0;
      ill_pipe_d = '0;
    end
  end

  // State register for all datapath and control flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      drv_q      <= NOP;
      ivld_q     <= 1'b0;
      itag_q     <= '0;
      iill_q     <= 1'b0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      ill_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      drv_q      <= drv_d;
      ivld_q     <= ivld_d;
      itag_q     <= itag_d;
      iill_q     <= iill_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      ill_pipe_q <= ill_pipe_d;
    end
  end

  assign A           = drv_q[2:0];
  assign B           = drv_q[5:3];
  assign opcode      = drv_q[8:6];
  assign Cin         = drv_q[9];
  assign serial_in   = drv_q[10];
  assign red_op_A    = drv_q[11];
  assign red_op_B    = drv_q[12];
  assign bypass_A    = drv_q[13];
  assign bypass_B    = drv_q[14];
  assign direction   = drv_q[15];
  assign issue_valid = ivld_q;
  assign rsp_valid   = vld_pipe_q[1];
  assign rsp_tag     = tag_pipe_q[1];
  assign illegal     = ill_pipe_q[1];
  assign fifo_count  = count_q;

`ifdef ALSU_ISSUER_STATS_EN
  logic [15:0] issued_cnt_q, issued_cnt_d, illegal_cnt_q, illegal_cnt_d;

  // Saturating counters. Flush does not clear them.
  always_comb begin
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop && issued_cnt_q != 16'hFFFF)              issued_cnt_d  = issued_cnt_q + 16'd1;
    if (pop && head_ill && illegal_cnt_q != 16'hFFFF) illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign issued_cnt  = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Directed bench for alsu_cmd_issuer (DEPTH=4). Inputs change 1ns after the
// rising edge, and outputs are sampled at that same point.
module tb_alsu_cmd_issuer;
  logic        clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [15:0] cmd_data = '0;
  logic [3:0]  cmd_tag = '0;
  logic        cmd_ready, Cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [2:0]  A, B, opcode, fifo_count;
  logic        issue_valid, rsp_valid, illegal;
  logic [3:0]  rsp_tag;
`ifdef ALSU_ISSUER_STATS_EN
  logic [15:0] issued_cnt, illegal_cnt;
`endif
  int compared = 0, mismatched = 0;

  localparam logic [15:0] NOP = 16'h2000;

  alsu_cmd_issuer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag), .hold(hold), .flush(flush),
    .A(A), .B(B), .opcode(opcode), .Cin(Cin), .serial_in(serial_in),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
    .bypass_B(bypass_B), .direction(direction), .issue_valid(issue_valid),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .illegal(illegal),
    .fifo_count(fifo_count)
`ifdef ALSU_ISSUER_STATS_EN
    , .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [15:0] drv = {direction, bypass_B, bypass_A, red_op_B, red_op_A,
                     serial_in, Cin, opcode, B, A};

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic cin,
                                     input logic ra, input logic rb);
    return {3'b000, rb, ra, 1'b0, cin, op, b, a};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] t);
    cmd_valid = v;
    cmd_data  = d;
    cmd_tag   = t;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_ivld", 16'(issue_valid), 16'd0);
    chk("rst_rvld", 16'(rsp_valid), 16'd0);
    chk("rst_rtag", 16'(rsp_tag), 16'd0);
    chk("rst_ill", 16'(illegal), 16'd0);
    chk("rst_drv", drv, NOP);
    rst = 1'b1;
    tick();

    // Three back-to-back commands. Each rsp follows its issue by two cycles.
    drive(1'b1, mk(3'd1, 3'd2, 3'b010, 1'b1, 1'b0, 1'b0), 4'd1);
    tick();
    chk("b2b_cnt1", 16'(fifo_count), 16'd1);
    chk("b2b_noiss", 16'(issue_valid), 16'd0);
    cmd_tag = 4'd2;
    tick();
    chk("b2b_iss1", 16'(issue_valid), 16'd1);
    chk("b2b_drv1", drv, 16'h0291);
    cmd_tag = 4'd3;
    tick();
    chk("b2b_iss2", 16'(issue_valid), 16'd1);
    drive(1'b0, '0, '0);
    tick();
    chk("b2b_iss3", 16'(issue_valid), 16'd1);
    chk("b2b_rsp1", {11'd0, rsp_valid, rsp_tag}, 16'h0011);
    chk("b2b_cnt0", 16'(fifo_count), 16'd0);
    tick();
    chk("b2b_idle", 16'(issue_valid), 16'd0);
    chk("b2b_nop", drv, NOP);
    chk("b2b_rsp2", {11'd0, rsp_valid, rsp_tag}, 16'h0012);
    tick();
    chk("b2b_rsp3", {11'd0, rsp_valid, rsp_tag}, 16'h0013);
    chk("b2b_legal", 16'(illegal), 16'd0);
    tick();
    chk("b2b_rspend", 16'(rsp_valid), 16'd0);

    // Fill the FIFO while hold is high. The 5th push must be ignored.
    hold = 1'b1;
    for (int t = 4; t <= 7; t++) begin
      drive(1'b1, mk(3'(t), 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'(t));
      tick();
    end
    chk("full_cnt", 16'(fifo_count), 16'd4);
    chk("full_ready", 16'(cmd_ready), 16'd0);
    drive(1'b1, mk(3'd0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'd8);
    tick();
    chk("full_ovf", 16'(fifo_count), 16'd4);
    chk("full_stall", 16'(issue_valid), 16'd0);
    drive(1'b0, '0, '0);
    hold = 1'b0;
    tick();
    chk("rel_wait", 16'(issue_valid), 16'd0);
    for (int t = 4; t <= 7; t++) begin
      tick();
      chk("rel_order", {7'd0, issue_valid, drv[7:0]}, 16'h0100 | 16'(t));
    end
    tick();
    chk("rel_done", 16'(issue_valid), 16'd0);
    chk("rel_cnt", 16'(fifo_count), 16'd0);
    chk("rel_rtag6", {11'd0, rsp_valid, rsp_tag}, 16'h0016);
    tick();
    chk("rel_rtag7", {11'd0, rsp_valid, rsp_tag}, 16'h0017);
    tick();

    // Full FIFO with a push and a pop in the same cycle
    hold = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      drive(1'b1, mk(3'(a), 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'(a + 8));
      tick();
    end
    drive(1'b1, mk(3'd5, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'd13);
    hold = 1'b0;
    #1;
    chk("pp_ready0", 16'(cmd_ready), 16'd0);
    tick();
    chk("pp_ready1", 16'(cmd_ready), 16'd1);
    chk("pp_cnt_a", 16'(fifo_count), 16'd4);
    tick();
    chk("pp_cnt_b", 16'(fifo_count), 16'd4);
    chk("pp_drv1", {7'd0, issue_valid, drv[7:0]}, 16'h0101);
    drive(1'b1, mk(3'd6, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'd14);
    tick();
    chk("pp_cnt_c", 16'(fifo_count), 16'd4);
    chk("pp_drv2", {7'd0, issue_valid, drv[7:0]}, 16'h0102);
    drive(1'b0, '0, '0);
    for (int a = 3; a <= 6; a++) begin
      tick();
      chk("pp_drain", {7'd0, issue_valid, drv[7:0]}, 16'h0100 | 16'(a));
      chk("pp_dcnt", 16'(fifo_count), 16'(6 - a));
    end
    tick();
    chk("pp_end", 16'(issue_valid), 16'd0);
    tick(); tick(); tick();

    // Illegal-case classification
    drive(1'b1, mk(3'd0, 3'd0, 3'b111, 1'b0, 1'b0, 1'b0), 4'd1);
    tick();
    drive(1'b1, mk(3'd0, 3'd0, 3'b011, 1'b0, 1'b1, 1'b0), 4'd2);
    tick();
    drive(1'b1, mk(3'd0, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0), 4'd3);
    tick();
    drive(1'b1, mk(3'd0, 3'd0, 3'b001, 1'b0, 1'b0, 1'b1), 4'd4);
    tick();
    drive(1'b0, '0, '0);
    chk("ill_op111", {10'd0, rsp_valid, illegal, rsp_tag}, 16'h0031);
    tick();
    chk("ill_op011r", {10'd0, rsp_valid, illegal, rsp_tag}, 16'h0032);
    tick();
    chk("ill_op000r", {10'd0, rsp_valid, illegal, rsp_tag}, 16'h0023);
    tick();
    chk("ill_op001r", {10'd0, rsp_valid, illegal, rsp_tag}, 16'h0024);
    tick(); tick();

    // Flush with two commands queued and two in flight. Flush also beats a push.
    hold = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      drive(1'b1, mk(3'(t), 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'(t));
      tick();
    end
    drive(1'b0, '0, '0);
    hold = 1'b0;
    tick();
    tick();
    tick();
    chk("fl_pre_cnt", 16'(fifo_count), 16'd2);
    chk("fl_pre_iss", 16'(issue_valid), 16'd1);
    flush = 1'b1;
    drive(1'b1, mk(3'd7, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'd9);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_cnt", 16'(fifo_count), 16'd0);
    chk("fl_nop", {7'd0, issue_valid, 8'd0} | drv, NOP);
    chk("fl_rvld0", 16'(rsp_valid), 16'd0);
    tick();
    chk("fl_rvld1", 16'(rsp_valid), 16'd0);
    chk("fl_iss1", 16'(issue_valid), 16'd0);
    tick();
    chk("fl_rvld2", 16'(rsp_valid), 16'd0);
    chk("fl_cnt2", 16'(fifo_count), 16'd0);

    // Reset during back-to-back issue
    hold = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      drive(1'b1, mk(3'(t), 3'd1, 3'b010, 1'b0, 1'b0, 1'b0), 4'(t));
      tick();
    end
    drive(1'b0, '0, '0);
    hold = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_pre_iss", 16'(issue_valid), 16'd1);
    rst = 1'b0;
    #1;
    chk("mr_cnt", 16'(fifo_count), 16'd0);
    chk("mr_ready", 16'(cmd_ready), 16'd1);
    chk("mr_iss", 16'(issue_valid), 16'd0);
    chk("mr_rsp", {10'd0, rsp_valid, illegal, rsp_tag}, 16'h0000);
    chk("mr_drv", drv, NOP);
`ifdef ALSU_ISSUER_STATS_EN
    chk("mr_issued_cnt", issued_cnt, 16'd0);
    chk("mr_illegal_cnt", illegal_cnt, 16'd0);
`endif
    tick();
    rst = 1'b1;
    tick();
    chk("mr_discard", {7'd0, issue_valid, 3'd0, fifo_count, 2'd0}, 16'h0000);
    drive(1'b1, mk(3'd5, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0), 4'd5);
    tick();
    drive(1'b0, '0, '0);
    chk("mr_lat0", 16'(issue_valid), 16'd0);
    tick();
    chk("mr_lat1", {7'd0, issue_valid, drv[7:0]}, 16'h0105);
    tick();
    tick();
    chk("mr_rsp5", {11'd0, rsp_valid, rsp_tag}, 16'h0015);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
